// File: rtl/dmem_responder_if.sv
// LSU <-> data-memory request/response bundle.
// master: the LSU side issuing requests; slave: the memory responder.
interface dmem_responder_if;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rvld;
  logic        mem_busy;
  logic        mem_err;

  modport master (
    output mem_en, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvld, mem_busy, mem_err
  );

  modport slave (
    input  mem_en, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_rvld, mem_busy, mem_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the LSU port of the five-stage core.
// Stores commit byte lanes at the request edge; loads return the full aligned
// word RD_LAT cycles later as a one-cycle mem_rvld pulse.
// Optional feature macro: DMEM_JITTER_EN adds 0..3 pseudo-random extra wait
// cycles per load, taken from an 8-bit LFSR.
//
//  state | meaning
//  IDLE  | no load outstanding, loads accepted
//  WAIT  | load outstanding; cnt counts down to the rvld cycle
module dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input logic        CLK,
  input logic        RSTN,
  dmem_responder_if.slave bus
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("dmem_responder: RD_LAT must be within 1..4");
  end

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic [31:0]       cap_q;
  logic [31:0]       rdata_q;
  logic              rvld_q;
  logic              err_q;
  logic [31:0]       mem_q [2**ADDR_W];

  logic              in_range;
  logic              is_load;
  logic              is_store;
  logic              ld_accept;
  logic              ld_collide;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       rd_word;
  logic [1:0]        extra;
  logic [2:0]        lat_init;
  logic              unused_addr_lsb;

  assign in_range   = (bus.mem_addr[31:ADDR_W+2] == '0);
  assign widx       = bus.mem_addr[ADDR_W+1:2];
  assign is_load    = bus.mem_en && (bus.mem_wen == 4'b0000);
  assign is_store   = bus.mem_en && (bus.mem_wen != 4'b0000);
  // A load may only enter while idle or in the very cycle the previous one responds.
  assign ld_accept  = is_load && ((state_q == IDLE) || rvld_q);
  assign ld_collide = is_load && (state_q == WAIT) && !rvld_q;
  assign rd_word    = in_range ? mem_q[widx] : 32'h0;
  assign lat_init   = 3'(RD_LAT - 1) + {1'b0, extra};
  // The byte offset has no meaning for a word-organised array.
  assign unused_addr_lsb = ^bus.mem_addr[1:0];

`ifdef DMEM_JITTER_EN
  logic [7:0] lfsr_q;

  // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR supplying the per-load jitter.
  always_ff @(posedge CLK) begin
    if (!RSTN) lfsr_q <= 8'hA5;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign extra = lfsr_q[1:0];
`else
  assign extra = 2'b00;
`endif

  // Byte-lane store commit; the array itself is deliberately never reset.
  always_ff @(posedge CLK) begin
    if (is_store && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_wen[i]) mem_q[widx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      end
    end
  end

  // Load sequencing FSM with registered rvld/rdata/err; data is sampled at accept.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      cap_q   <= 32'h0;
      rdata_q <= 32'h0;
      rvld_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (bus.mem_en && !in_range) || ld_collide;
      if (ld_accept) begin
        state_q <= WAIT;
        cnt_q   <= lat_init;
        cap_q   <= rd_word;
        rvld_q  <= (lat_init == 3'd0);
        if (lat_init == 3'd0) rdata_q <= rd_word;
      end else if (state_q == WAIT) begin
        if (rvld_q) begin
          state_q <= IDLE;
          rvld_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            rvld_q  <= 1'b1;
            rdata_q <= cap_q;
          end
        end
      end else begin
        rvld_q <= 1'b0;
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_rvld  = rvld_q;
  assign bus.mem_busy  = (state_q == WAIT);
  assign bus.mem_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (RD_LAT=1 and RD_LAT=3)
// share one request stream; a byte-level reference model predicts responses.
module tb_dmem_responder;
  localparam int ADDR_W = 10;
  localparam int NCYC   = 8192;

  typedef struct {
    int          c;
    logic [31:0] d;
  } rsp_t;

  logic        CLK  = 1'b0;
  logic        RSTN = 1'b0;
  logic        en   = 1'b0;
  logic [3:0]  wen  = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  always #5 CLK = ~CLK;

  dmem_responder_if bus1 ();
  dmem_responder_if bus3 ();

  assign bus1.mem_en = en;  assign bus1.mem_wen = wen;
  assign bus1.mem_addr = addr;  assign bus1.mem_wdata = wdata;
  assign bus3.mem_en = en;  assign bus3.mem_wen = wen;
  assign bus3.mem_addr = addr;  assign bus3.mem_wdata = wdata;

  dmem_responder #(.ADDR_W(ADDR_W), .RD_LAT(1)) u_dut1 (.CLK(CLK), .RSTN(RSTN), .bus(bus1.slave));
  dmem_responder #(.ADDR_W(ADDR_W), .RD_LAT(3)) u_dut3 (.CLK(CLK), .RSTN(RSTN), .bus(bus3.slave));

  // Reference state
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mbyte [int];
  int          pend [2] = '{-1, -1};
  int          lat  [2] = '{1, 3};
  bit          exp_err  [2][NCYC];
  bit          exp_busy [2][NCYC];
  rsp_t        q0 [$];
  rsp_t        q1 [$];
  logic [31:0] exp_rd  [2] = '{32'h0, 32'h0};
  logic [31:0] last_rv [2] = '{32'h0, 32'h0};
  bit          mon_on = 1'b0;
  bit          rst_prev = 1'b1;

  always @(posedge CLK) cyc <= cyc + 1;

`ifdef DMEM_JITTER_EN
  logic [7:0] m_lfsr = 8'hA5;
  always @(posedge CLK)
    m_lfsr <= RSTN ? {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]} : 8'hA5;
`endif

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, lat[d], cyc, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic rsp_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int d, input rsp_t r);
    if (d == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  function automatic logic [31:0] model_word(input int w);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < 4; i++)
      if (mbyte.exists(w*4 + i)) v[8*i +: 8] = mbyte[w*4 + i];
    return v;
  endfunction

  // Apply the request currently on the bus (cycle cyc) to the reference model.
  task automatic model_req();
    int   c = cyc;
    bit   inr;
    int   w;
    int   l;
    rsp_t r;
    if (!en) return;
    inr = (addr[31:ADDR_W+2] == '0);
    w   = int'(addr[ADDR_W+1:2]);
    if (wen != 4'h0) begin
      if (inr) begin
        for (int i = 0; i < 4; i++)
          if (wen[i]) mbyte[w*4 + i] = wdata[8*i +: 8];
      end else begin
        exp_err[0][c+1] = 1'b1;
        exp_err[1][c+1] = 1'b1;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        l = lat[d];
`ifdef DMEM_JITTER_EN
        l = l + int'(m_lfsr[1:0]);
`endif
        if (pend[d] > c) begin
          exp_err[d][c+1] = 1'b1;
        end else begin
          pend[d] = c + l;
          r.c = c + l;
          r.d = inr ? model_word(w) : 32'h0;
          qpush(d, r);
          for (int k = 1; k <= l; k++) exp_busy[d][c+k] = 1'b1;
          if (!inr) exp_err[d][c+1] = 1'b1;
        end
      end
    end
  endtask

  // Reset asserted in cycle c: anything predicted after this cycle is dropped.
  task automatic model_reset(input int c);
    for (int d = 0; d < 2; d++) begin
      pend[d] = -1;
      for (int k = c + 1; k <= c + 8; k++) begin
        exp_err[d][k]  = 1'b0;
        exp_busy[d][k] = 1'b0;
      end
    end
    while (q0.size() > 0 && q0[q0.size()-1].c > c) void'(q0.pop_back());
    while (q1.size() > 0 && q1[q1.size()-1].c > c) void'(q1.pop_back());
  endtask

  task automatic drive(input logic e, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
    @(posedge CLK); #1;
    en = e; wen = we; addr = a; wdata = wd;
    model_req();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    @(posedge CLK); #1;
    RSTN = 1'b0; en = 1'b0;
    model_reset(cyc);
    repeat (n - 1) @(posedge CLK);
    @(posedge CLK); #1;
    RSTN = 1'b1;
  endtask

  task automatic check_dut(input int d, input logic rvld, input logic [31:0] rdata,
                           input logic busy, input logic err);
    rsp_t r;
    chk("err", d, {31'h0, err}, {31'h0, exp_err[d][cyc]});
    chk("busy", d, {31'h0, busy}, {31'h0, exp_busy[d][cyc]});
    if (rvld) begin
      if (qsize(d) == 0) begin
        chk("rvld_unexpected", d, 32'h1, 32'h0);
      end else begin
        r = qfront(d);
        qpop(d);
        chk("rvld_cycle", d, cyc, r.c);
        chk("rdata", d, rdata, r.d);
        exp_rd[d]  = r.d;
        last_rv[d] = rdata;
      end
    end else begin
      if (qsize(d) > 0 && qfront(d).c <= cyc) begin
        chk("rvld_missing", d, 32'h0, 32'h1);
        qpop(d);
      end
      chk("rdata_hold", d, rdata, exp_rd[d]);
    end
  endtask

  // Monitor: compares every observable output each cycle against predictions.
  always @(negedge CLK) begin
    if (mon_on && cyc < NCYC - 16) begin
      if (rst_prev) begin
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
      end
      check_dut(0, bus1.mem_rvld, bus1.mem_rdata, bus1.mem_busy, bus1.mem_err);
      check_dut(1, bus3.mem_rvld, bus3.mem_rdata, bus3.mem_busy, bus3.mem_err);
      rst_prev = !RSTN;
    end
  end

  initial begin
    logic [31:0] a;
    int          r;
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTN   = 1'b1;
    mon_on = 1'b1;

    // Fill the 16-word pool used by random traffic.
    for (int w = 0; w < 16; w++) drive(1'b1, 4'hF, 32'(w*4), $urandom);

    // Store then load, same word.
    drive(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    drive(1'b1, 4'h0, 32'h10, 32'h0);
    idle(5);
    for (int d = 0; d < 2; d++) chk("store_load", d, last_rv[d], 32'hDEADBEEF);

    // Byte-lane merge.
    drive(1'b1, 4'hF, 32'h20, 32'h11223344);
    drive(1'b1, 4'h4, 32'h22, 32'h00AB0000);
    drive(1'b1, 4'h0, 32'h20, 32'h0);
    idle(5);
    for (int d = 0; d < 2; d++) chk("lane_merge", d, last_rv[d], 32'h11AB3344);

    // Consecutive loads: collision on the RD_LAT=3 instance, back-to-back on RD_LAT=1.
    drive(1'b1, 4'h0, 32'h10, 32'h0);
    drive(1'b1, 4'h0, 32'h20, 32'h0);
    idle(3);
    // Load during WAIT followed by a store to the captured word.
    drive(1'b1, 4'h0, 32'h14, 32'h0);
    drive(1'b1, 4'hF, 32'h14, 32'h12345678);
    idle(5);

    // Out-of-range load and store; word 0 must be untouched.
    drive(1'b1, 4'h0, 32'h00001000, 32'h0);
    idle(4);
    drive(1'b1, 4'hF, 32'h00001000, 32'hCAFEF00D);
    drive(1'b1, 4'h0, 32'h0, 32'h0);
    idle(5);

    // Reset one cycle after a load.
    drive(1'b1, 4'h0, 32'h18, 32'h0);
    do_reset(2);
    idle(6);

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 199));
      if (r < 2) begin
        do_reset(2);
      end else if (r < 60) begin
        idle(1);
      end else begin
        if ($urandom_range(0, 9) == 0)
          a = ($urandom & 32'hFFFF_FFFF) | (32'h1 << (12 + $urandom_range(0, 19)));
        else
          a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) drive(1'b1, 4'h0, a, $urandom);
        else                          drive(1'b1, 4'($urandom_range(1, 15)), a, $urandom);
      end
    end

    idle(12);
    for (int d = 0; d < 2; d++) chk("drain", d, qsize(d), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
